// File: rtl/frame_mem_arbiter.sv
// Single-port frame memory arbiter: reads win every cycle, writes are posted through a FIFO.
// Optional statistics counters are built when FMEM_ARB_STATS_EN is defined.
module frame_mem_arbiter #(
    parameter int DATA_WIDTH  = 24,
    parameter int MEM_WIDTH   = DATA_WIDTH * 4,
    parameter int ADDR_DEPTH  = 512 * 512 / 4,
    parameter int ADDR_WIDTH  = $clog2(ADDR_DEPTH),
    parameter int MEM_LAT     = 3,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              rst,
    input  logic                              i_rreq,
    input  logic [ADDR_WIDTH-1:0]             i_raddr,
    output logic                              o_rvalid,
    output logic [MEM_WIDTH-1:0]              o_rdata,
    input  logic                              i_wreq,
    input  logic [ADDR_WIDTH-1:0]             i_waddr,
    input  logic [MEM_WIDTH-1:0]              i_wdata,
    output logic                              o_wready,
    output logic                              o_wr_ovf,
    input  logic                              i_ovf_clr,
    output logic                              o_mem_cs,
    output logic                              o_mem_we,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [MEM_WIDTH-1:0]              o_mem_wdata,
    input  logic [MEM_WIDTH-1:0]              i_mem_rdata,
    output logic [15:0]                       o_turn_cnt,
    output logic [$clog2(WFIFO_DEPTH):0]      o_max_fill
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_TURN  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_nxt_s;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [ADDR_WIDTH-1:0]  fifo_addr_r [WFIFO_DEPTH];
    logic [MEM_WIDTH-1:0]   fifo_data_r [WFIFO_DEPTH];
    logic                   fifo_empty_s;
    logic                   wready_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   mem_cs_r;
    logic                   mem_we_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic [MEM_WIDTH-1:0]   mem_wdata_r;
    logic                   wr_ovf_r;
    logic [MEM_LAT-1:0]     vld_sr_r;

    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign wready_s     = (count_r < CNT_W'(WFIFO_DEPTH));
    assign push_s       = i_wreq && wready_s;
    // Every cycle spent in S_WRITE consumes one FIFO entry, taken on the edge that enters it.
    assign pop_s        = (state_nxt_s == S_WRITE);

    // Next-state decode; a read request overrides everything else.
    always_comb begin
        state_nxt_s = state_r;
        if (i_rreq) begin
            state_nxt_s = S_READ;
        end else begin
            case (state_r)
                S_IDLE:  state_nxt_s = fifo_empty_s ? S_IDLE : S_WRITE;
                S_READ:  state_nxt_s = fifo_empty_s ? S_IDLE : S_TURN;
                S_TURN:  state_nxt_s = S_WRITE;
                S_WRITE: state_nxt_s = fifo_empty_s ? S_IDLE : S_WRITE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // State register and memory command outputs.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {MEM_WIDTH{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            mem_cs_r <= (state_nxt_s == S_READ) || (state_nxt_s == S_WRITE);
            mem_we_r <= (state_nxt_s == S_WRITE);
            if (state_nxt_s == S_READ) begin
                mem_addr_r <= i_raddr;
            end else if (pop_s) begin
                mem_addr_r  <= fifo_addr_r[rd_ptr_r];
                mem_wdata_r <= fifo_data_r[rd_ptr_r];
            end
        end
    end

    // FIFO pointers and count; storage contents are irrelevant once the count is cleared.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= i_waddr;
            fifo_data_r[wr_ptr_r] <= i_wdata;
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            wr_ovf_r <= 1'b0;
        end else if (i_wreq && !wready_s) begin
            wr_ovf_r <= 1'b1;
        end else if (i_ovf_clr) begin
            wr_ovf_r <= 1'b0;
        end
    end

    // Read-valid pipeline tracking each read command through the memory latency.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            vld_sr_r <= {MEM_LAT{1'b0}};
        end else begin
            vld_sr_r <= (vld_sr_r << 1) | MEM_LAT'(state_r == S_READ);
        end
    end

    assign o_mem_cs    = mem_cs_r;
    assign o_mem_we    = mem_we_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_wready    = wready_s;
    assign o_wr_ovf    = wr_ovf_r;
    assign o_rvalid    = vld_sr_r[MEM_LAT-1];
    assign o_rdata     = o_rvalid ? i_mem_rdata : {MEM_WIDTH{1'b0}};

`ifdef FMEM_ARB_STATS_EN
    logic [15:0]      turn_cnt_r;
    logic [CNT_W-1:0] max_fill_r;

    // Turnaround counter (saturating) and FIFO high-water mark.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            turn_cnt_r <= 16'h0000;
            max_fill_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == S_TURN) && (turn_cnt_r != 16'hFFFF)) begin
                turn_cnt_r <= turn_cnt_r + 16'h0001;
            end
            if (count_nxt_s > max_fill_r) begin
                max_fill_r <= count_nxt_s;
            end
        end
    end

    assign o_turn_cnt = turn_cnt_r;
    assign o_max_fill = max_fill_r;
`else
    assign o_turn_cnt = 16'h0000;
    assign o_max_fill = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter: directed command sequences plus randomized traffic
// checked against a queue-based model of posted writes, read latency and memory contents.
module tb_frame_mem_arbiter;

    localparam int MW    = 96;
    localparam int AW    = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int FW    = 3;

    logic          i_clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_rreq = 1'b0;
    logic [AW-1:0] i_raddr = '0;
    logic          o_rvalid;
    logic [MW-1:0] o_rdata;
    logic          i_wreq = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic [MW-1:0] i_wdata = '0;
    logic          o_wready;
    logic          o_wr_ovf;
    logic          i_ovf_clr = 1'b0;
    logic          o_mem_cs;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [MW-1:0] o_mem_wdata;
    logic [MW-1:0] i_mem_rdata = '0;
    logic [15:0]   o_turn_cnt;
    logic [FW-1:0] o_max_fill;

    frame_mem_arbiter dut (
        .i_clk(i_clk), .rst(rst),
        .i_rreq(i_rreq), .i_raddr(i_raddr), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .i_wreq(i_wreq), .i_waddr(i_waddr), .i_wdata(i_wdata), .o_wready(o_wready),
        .o_wr_ovf(o_wr_ovf), .i_ovf_clr(i_ovf_clr),
        .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_turn_cnt(o_turn_cnt), .o_max_fill(o_max_fill)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [AW-1:0] a; logic [MW-1:0] d; } wr_t;
    typedef struct { int due; logic [AW-1:0] a; } rd_t;
    typedef struct { int due; logic [MW-1:0] d; } rv_t;

    wr_t exp_wq[$];
    rd_t exp_rq[$];
    rv_t exp_vq[$];
    logic [MW-1:0] ref_mem [int];
    logic [MW-1:0] mdl_mem [int];
    logic [MW-1:0] pipe [LAT] = '{default: '0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int writes_seen = 0;
    bit ovf_m = 1'b0;
    bit prev_rd = 1'b0;
    wr_t mon_w;
    rd_t mon_r;
    rv_t mon_v;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [MW-1:0] init_val(int a);
        return MW'(a);
    endfunction

    function automatic logic [MW-1:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [MW-1:0] mdl_rd(int a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
    endfunction

    // Stimulus observer and memory macro model, both acting on the active edge.
    always @(posedge i_clk) begin
        cyc++;
        if (!rst) begin
            if (i_wreq && o_wready) begin
                exp_wq.push_back('{i_waddr, i_wdata});
                pushes++;
            end
            if (i_wreq && !o_wready) ovf_m = 1'b1;
            else if (i_ovf_clr) ovf_m = 1'b0;
            if (i_rreq) exp_rq.push_back('{cyc, i_raddr});
        end
        if (o_mem_cs && o_mem_we) mdl_mem[int'(o_mem_addr)] = o_mem_wdata;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = (o_mem_cs && !o_mem_we) ? mdl_rd(int'(o_mem_addr)) : {3{32'hdeadbeef}};
        i_mem_rdata = pipe[LAT-1];
    end

    // Monitor: compares memory commands and read returns against the scoreboard queues.
    always @(negedge i_clk) begin
        if (!rst) begin
            if (o_mem_cs && !o_mem_we) begin
                if (exp_rq.size() == 0) chk("read_unexpected_q", exp_rq.size(), 1);
                else begin
                    mon_r = exp_rq.pop_front();
                    chk("read_cycle", cyc, mon_r.due);
                    chk("read_addr", o_mem_addr, mon_r.a);
                    exp_vq.push_back('{cyc + LAT, ref_rd(int'(mon_r.a))});
                end
            end else if (exp_rq.size() != 0 && exp_rq[0].due <= cyc) begin
                chk("read_missing", {o_mem_cs, o_mem_we}, 2'b10);
                void'(exp_rq.pop_front());
            end
            if (o_mem_cs && o_mem_we) begin
                chk("turnaround", prev_rd, 1'b0);
                if (exp_wq.size() == 0) chk("write_unexpected_q", exp_wq.size(), 1);
                else begin
                    mon_w = exp_wq.pop_front();
                    chk("write_addr", o_mem_addr, mon_w.a);
                    chk("write_data", o_mem_wdata, mon_w.d);
                    ref_mem[int'(mon_w.a)] = mon_w.d;
                    writes_seen++;
                end
            end
            prev_rd = o_mem_cs && !o_mem_we;
            if (o_rvalid) begin
                if (exp_vq.size() == 0) chk("rvalid_unexpected_q", exp_vq.size(), 1);
                else begin
                    mon_v = exp_vq.pop_front();
                    chk("rvalid_cycle", cyc, mon_v.due);
                    chk("rdata", o_rdata, mon_v.d);
                end
            end else begin
                chk("rdata_idle", o_rdata, '0);
                if (exp_vq.size() != 0 && exp_vq[0].due <= cyc) begin
                    chk("rvalid_missing", o_rvalid, 1'b1);
                    void'(exp_vq.pop_front());
                end
            end
            chk("wready", o_wready, (pushes - writes_seen) < DEPTH);
            chk("wr_ovf", o_wr_ovf, ovf_m);
        end
    end

    // One directed step per character; exp_s gives the command seen after each edge.
    task automatic run_seq(string rq, string wq, string exp_s);
        byte code;
        for (int t = 0; t < exp_s.len(); t++) begin
            i_rreq  = (t < rq.len()) && (rq[t] == "r");
            i_raddr = AW'(t);
            i_wreq  = (t < wq.len()) && (wq[t] == "w");
            i_waddr = AW'($urandom_range(0, 15));
            i_wdata = {$urandom, $urandom, $urandom};
            @(negedge i_clk);
            code = !o_mem_cs ? "." : (o_mem_we ? "W" : "R");
            chk("cmd_seq", code, exp_s[t]);
        end
        i_rreq = 1'b0;
        i_wreq = 1'b0;
    endtask

    task automatic idle(int n);
        i_rreq = 1'b0; i_wreq = 1'b0; i_ovf_clr = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk_stats(int turn, int fill);
`ifdef FMEM_ARB_STATS_EN
        chk("turn_cnt", o_turn_cnt, turn);
        chk("max_fill", o_max_fill, fill);
`else
        chk("turn_cnt_off", o_turn_cnt, 16'h0000);
        chk("max_fill_off", o_max_fill, 3'd0);
`endif
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_cs"}, o_mem_cs, 1'b0);
        chk({tag, "_we"}, o_mem_we, 1'b0);
        chk({tag, "_addr"}, o_mem_addr, '0);
        chk({tag, "_wdata"}, o_mem_wdata, '0);
        chk({tag, "_rvalid"}, o_rvalid, 1'b0);
        chk({tag, "_rdata"}, o_rdata, '0);
        chk({tag, "_wready"}, o_wready, 1'b1);
        chk({tag, "_ovf"}, o_wr_ovf, 1'b0);
        chk_stats(0, 0);
    endtask

    initial begin
        #3;
        chk_reset_outputs("rst");
        @(negedge i_clk);
        #2 rst = 1'b0;

        run_seq("rrrrrrrr", "", "RRRRRRRR....");
        run_seq("", "www", ".WWW..");
        run_seq("..rr", "ww", ".WRR.W..");
        chk_stats(1, 1);
        run_seq("rrr", "www", "RRR.WWW..");
        chk_stats(2, 3);
        run_seq("rrrrrr", "wwwwww", "RRRRRR.WWWW..");
        chk("ovf_after_drop", o_wr_ovf, 1'b1);
        chk_stats(3, 4);
        i_ovf_clr = 1'b1;
        @(negedge i_clk);
        i_ovf_clr = 1'b0;
        chk("ovf_cleared", o_wr_ovf, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            i_rreq    = $urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 85 : 25);
            i_raddr   = AW'($urandom_range(0, 15));
            i_wreq    = $urandom_range(0, 99) < 50;
            i_waddr   = AW'($urandom_range(0, 15));
            i_wdata   = {$urandom, $urandom, $urandom};
            i_ovf_clr = $urandom_range(0, 99) < 5;
            @(negedge i_clk);
        end
        idle(30);
        chk("drain_wq_empty", exp_wq.size(), 0);
        chk("drain_rq_empty", exp_rq.size(), 0);
        chk("drain_vq_empty", exp_vq.size(), 0);

        run_seq("rrr", "ww", "RRR");
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        exp_wq.delete();
        exp_rq.delete();
        exp_vq.delete();
        pushes = 0;
        writes_seen = 0;
        ovf_m = 1'b0;
        #1 rst = 1'b0;
        idle(12);
        chk("post_rst_wready", o_wready, 1'b1);
        chk_stats(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Single-port frame memory arbiter sharing one SRAM port between the write side (input capture, posted writes) and the read side (display readout, hard real-time). Reads have absolute priority and never stall. Writes are buffered in a small FIFO and drained in idle slots, with one turnaround bubble on every read-to-write switch. Sits between memory write/read control and the frame memory macro.

## Interface
- DATA_WIDTH, 24, pixel width.
- MEM_WIDTH, DATA_WIDTH*4, memory word width (2x2 pixel block).
- ADDR_DEPTH, 512*512/4, memory words.
- ADDR_WIDTH, $clog2(ADDR_DEPTH), word address width.
- MEM_LAT, 3, memory read latency in clocks, command to `i_mem_rdata` valid.
- WFIFO_DEPTH, 4, write FIFO entries; power of two, ≥2.

- i_clk  input  1  clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- i_rreq  input  1  read request, sampled every cycle, never back-pressured.
- i_raddr  input  ADDR_WIDTH  read word address.
- o_rvalid  output  1  read data valid.
- o_rdata  output  MEM_WIDTH  read data.
- i_wreq  input  1  write request.
- i_waddr  input  ADDR_WIDTH  write word address.
- i_wdata  input  MEM_WIDTH  write data.
- o_wready  output  1  FIFO has space; write accepted when `i_wreq && o_wready`.
- o_wr_ovf  output  1  sticky: write offered while `o_wready`=0 (data dropped).
- i_ovf_clr  input  1  clears `o_wr_ovf`.
- o_mem_cs  output  1  memory command strobe.
- o_mem_we  output  1  1 = write, 0 = read (valid when `o_mem_cs`).
- o_mem_addr  output  ADDR_WIDTH  memory address.
- o_mem_wdata  output  MEM_WIDTH  memory write data.
- i_mem_rdata  input  MEM_WIDTH  memory read data.
- o_turn_cnt  output  16  stats: turnaround cycles (see Configuration).
- o_max_fill  output  $clog2(WFIFO_DEPTH)+1  stats: FIFO high-water mark.

## Operation
- FSM states S_IDLE, S_READ, S_TURN, S_WRITE. The state register drives the memory command: `o_mem_cs` = (S_READ|S_WRITE); `o_mem_we` = S_WRITE.
- Next-state rules, with `i_rreq` checked first in every state:
  - any state, `i_rreq`=1 → S_READ.
  - S_IDLE: FIFO non-empty → S_WRITE, else S_IDLE.
  - S_READ: FIFO non-empty → S_TURN, else S_IDLE.
  - S_TURN → S_WRITE.
  - S_WRITE: FIFO non-empty after this cycle's pop/push → S_WRITE, else S_IDLE.
- Write→read switches need no bubble. Read→write always passes through one S_TURN cycle.
- Entering S_READ registers `i_raddr` into `o_mem_addr`.
- Entering S_WRITE pops the FIFO head into `o_mem_addr`/`o_mem_wdata`.
- FIFO order is preserved. There is no read-after-write forwarding: a read returns the memory contents, not pending FIFO data.
- FIFO occupancy:
  - push on accepted write; pop on transition into S_WRITE; simultaneous push+pop leaves count unchanged.
  - `o_wready` = count < WFIFO_DEPTH, decoded from the registered count.
- `o_wr_ovf` sets on `i_wreq && !o_wready`. Set wins over a simultaneous `i_ovf_clr`.
- Reset mid-operation: FIFO contents are discarded, and in-flight read valids are cleared.

## Timing
- Reset values:
  - state S_IDLE.
  - `o_mem_cs`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata` = 0.
  - `o_rvalid`=0, `o_rdata`=0.
  - `o_wready`=1, `o_wr_ovf`=0, FIFO count 0, stats 0.
- Read latency: `i_rreq` sampled at edge N → `o_mem_cs` at N+1 → `o_rvalid` high at N+1+MEM_LAT (4 cycles by default).
  - `o_rvalid` comes from a MEM_LAT-deep valid shift register.
  - `o_rdata` = `i_mem_rdata` when `o_rvalid`, else 0.
- Back-to-back reads give one result per cycle.
- Write latency from acceptance to `o_mem_cs`:
  - minimum 2 cycles (push at N, state S_WRITE at N+1 when idle).
  - unbounded under continuous reads; writes drain only in read gaps.

## Configuration
- `FMEM_ARB_STATS_EN` defined:
  - `o_turn_cnt` increments (saturating at 16'hFFFF) each cycle in S_TURN.
  - `o_max_fill` tracks the maximum FIFO count since reset.
- Not defined: both outputs are tied to 0 and the counters are not built.

## Test plan
- Reads: reset, then `i_rreq` for 8 cycles, addrs 0..7, memory model returns addr → `o_mem_cs`/`o_mem_we`=0 cycles 1..8, `o_rvalid` cycles 4..11 with data 0..7, `o_wready`=1 throughout.
- Write drain: 3 writes (addr 10..12) with no reads → S_WRITE for 3 consecutive cycles starting 1 cycle after the first push, in order, then S_IDLE; no S_TURN.
- Read preemption: 2 writes queued, then `i_rreq` asserted during the first S_WRITE for 2 cycles:
  - reads issue immediately.
  - then exactly one S_TURN cycle, then the remaining write.
  - stats build: `o_turn_cnt`=1.
- Overflow: 6 back-to-back writes while `i_rreq` is held high → `o_wready` low after the 4th, `o_wr_ovf`=1, writes 5-6 dropped.
  - Drop `i_rreq`: writes 1-4 drain after 1 turnaround.
  - `i_ovf_clr` → `o_wr_ovf`=0.
- Async reset pulsed while FIFO holds 2 entries and a read is in flight → all outputs reset immediately, no `o_rvalid`, no later memory writes.
- With `FMEM_ARB_STATS_EN`: fill FIFO to 3 → `o_max_fill`=3, unchanged after drain. Without the macro, both stats outputs read 0.
